// File: rtl/cmd_fetcher_pkg.sv
// Shared command-format constants and state encoding for the fetcher and executor.
// Header word: [5:0] flags, [7:6] argc, [31:8] reserved.
package cmd_fetcher_pkg;

  localparam int unsigned FL_LSB   = 0;
  localparam int unsigned FL_W     = 6;
  localparam int unsigned ARGC_LSB = 6;
  localparam int unsigned ARGC_W   = 2;
  localparam int unsigned MAX_ARGS = 3;
  localparam int unsigned ARG_W    = 32;
  localparam int unsigned IDX_W    = 2;

  localparam logic [FL_W-1:0] FL_HALT = '0;

  typedef enum logic [2:0] {
    StIdle,
    StFetchHdr,
    StFetchArg,
    StIssue,
    StHalt
  } state_e;

  function automatic logic [FL_W-1:0] hdr_flags(input logic [ARG_W-1:0] word);
    return word[FL_LSB +: FL_W];
  endfunction

  function automatic logic [ARGC_W-1:0] hdr_argc(input logic [ARG_W-1:0] word);
    return word[ARGC_LSB +: ARGC_W];
  endfunction

endpackage

// File: rtl/cmd_fetcher_arg_packer.sv
// Argument assembly: slot index counter and the packed 96-bit argument register.
// done_o flags the capture that fills the last slot announced by the header.
module cmd_arg_packer
  import cmd_fetcher_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      capture_i,
  input  logic [ARG_W-1:0]          data_i,
  input  logic [ARGC_W-1:0]         argc_i,
  output logic                      done_o,
  output logic [MAX_ARGS*ARG_W-1:0] args_o
);

  logic [IDX_W-1:0]          idx_d, idx_q;
  logic [MAX_ARGS*ARG_W-1:0] args_d, args_q;

  always_comb begin
    idx_d  = idx_q;
    args_d = args_q;
    if (clear_i) begin
      idx_d  = '0;
      args_d = '0;
    end else if (capture_i) begin
      for (int s = 0; s < MAX_ARGS; s++) begin
        if (idx_q == IDX_W'(s)) begin
          args_d[s*ARG_W +: ARG_W] = data_i;
        end
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Widened compare so idx+1 cannot wrap back to a small argc.
  always_comb begin
    done_o = capture_i && (({1'b0, idx_q} + 3'd1) == {1'b0, argc_i});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      args_q <= '0;
    end else begin
      idx_q  <= idx_d;
      args_q <= args_d;
    end
  end

  assign args_o = args_q;

endmodule

// File: rtl/cmd_fetcher.sv
// Command fetch front end: reads header and argument words from program memory,
// presents the bundle to the executor and applies its jump decision to the PC.
module cmd_fetcher
  import cmd_fetcher_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK_,
  input  logic              RST_,
  input  logic              START_,
  output logic              MEM_RD_EN_,
  output logic [ADDR_W-1:0] MEM_ADDR_,
  input  logic [31:0]       MEM_DATA_,
  input  logic              MEM_VALID_,
  output logic              CMD_VALID_,
  output logic [5:0]        CMD_FL_,
  output logic [95:0]       CMD_ARG_,
  input  logic              READY_FL_,
  input  logic              JMP_FL_,
  input  logic [31:0]       NEW_EXEC_ADDR_OFF_,
  output logic [ADDR_W-1:0] PC_,
  output logic              HALTED_
);

  state_e state_d, state_q;

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [FL_W-1:0]   flags_d, flags_q;
  logic [ARGC_W-1:0] argc_d, argc_q;

  logic              arg_clear, arg_capture, arg_done;
  logic [FL_W-1:0]   hdr_fl;
  logic [ARGC_W-1:0] hdr_ac;
  logic              hdr_is_halt;
  logic [ADDR_W-1:0] off_ext, jump_pc, seq_pc, next_pc;

  assign hdr_fl      = hdr_flags(MEM_DATA_);
  assign hdr_ac      = hdr_argc(MEM_DATA_);
  assign hdr_is_halt = (hdr_fl == FL_HALT);

  // Offset is relative to the header address; sign-extend or truncate to the PC width.
  assign off_ext = ADDR_W'($signed(NEW_EXEC_ADDR_OFF_));
  assign jump_pc = pc_q + off_ext;
  assign seq_pc  = pc_q + ADDR_W'(argc_q) + ADDR_W'(1);
  assign next_pc = JMP_FL_ ? jump_pc : seq_pc;

  // State register
  always_ff @(posedge CLK_ or posedge RST_) begin
    if (RST_) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (START_) state_d = StFetchHdr;
      end
      StFetchHdr: begin
        if (MEM_VALID_) begin
          if (hdr_is_halt) begin
            state_d = StHalt;
          end else if (hdr_ac == '0) begin
            state_d = StIssue;
          end else begin
            state_d = StFetchArg;
          end
        end
      end
      StFetchArg: begin
        if (arg_done) state_d = StIssue;
      end
      StIssue: begin
        if (READY_FL_) state_d = StFetchHdr;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    MEM_RD_EN_ = 1'b0;
    CMD_VALID_ = 1'b0;
    HALTED_    = 1'b0;
    case (state_q)
      StFetchHdr, StFetchArg: MEM_RD_EN_ = 1'b1;
      StIssue:                CMD_VALID_ = 1'b1;
      StHalt:                 HALTED_    = 1'b1;
      default: ;
    endcase
  end

  // PC, address and header-field datapath
  always_comb begin
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    flags_d     = flags_q;
    argc_d      = argc_q;
    arg_clear   = 1'b0;
    arg_capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (START_) mem_addr_d = pc_q;
      end
      StFetchHdr: begin
        if (MEM_VALID_) begin
          flags_d   = hdr_fl;
          argc_d    = hdr_ac;
          arg_clear = 1'b1;
          if (!hdr_is_halt && (hdr_ac != '0)) begin
            mem_addr_d = pc_q + ADDR_W'(1);
          end
        end
      end
      StFetchArg: begin
        if (MEM_VALID_) begin
          arg_capture = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
        end
      end
      StIssue: begin
        if (READY_FL_) begin
          pc_d       = next_pc;
          mem_addr_d = next_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_ or posedge RST_) begin
    if (RST_) begin
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      flags_q    <= '0;
      argc_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      flags_q    <= flags_d;
      argc_q     <= argc_d;
    end
  end

  cmd_arg_packer u_arg_packer (
    .clk_i     (CLK_),
    .rst_i     (RST_),
    .clear_i   (arg_clear),
    .capture_i (arg_capture),
    .data_i    (MEM_DATA_),
    .argc_i    (argc_q),
    .done_o    (arg_done),
    .args_o    (CMD_ARG_)
  );

  assign CMD_FL_   = flags_q;
  assign PC_       = pc_q;
  assign MEM_ADDR_ = mem_addr_q;

endmodule

// File: tb/tb_cmd_fetcher.sv
// Directed bench for cmd_fetcher with a behavioural program memory that answers
// read requests after a fixed or random delay.
module tb_cmd_fetcher;

  logic        clk = 1'b0;
  logic        rst, start, ready, jmp;
  logic        mem_rd_en, mem_valid, cmd_valid, halted;
  logic [31:0] mem_addr, mem_data, off, pc;
  logic [5:0]  cmd_fl;
  logic [95:0] cmd_arg;

  logic [31:0] mem [256];
  logic [31:0] addr_log [$];

  int n_checks = 0;
  int n_fail   = 0;

  bit          mem_auto, rand_mode, stale_pulse;
  bit          resp_busy;
  int          resp_cnt, resp_dly;
  int          unstable = 0;
  logic [31:0] req_addr;

  always #5 clk = ~clk;

  cmd_fetcher dut (
    .CLK_               (clk),
    .RST_               (rst),
    .START_             (start),
    .MEM_RD_EN_         (mem_rd_en),
    .MEM_ADDR_          (mem_addr),
    .MEM_DATA_          (mem_data),
    .MEM_VALID_         (mem_valid),
    .CMD_VALID_         (cmd_valid),
    .CMD_FL_            (cmd_fl),
    .CMD_ARG_           (cmd_arg),
    .READY_FL_          (ready),
    .JMP_FL_            (jmp),
    .NEW_EXEC_ADDR_OFF_ (off),
    .PC_                (pc),
    .HALTED_            (halted)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: acts just after the falling edge so it sees the bench's own updates.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    resp_busy = 1'b0;
    resp_cnt  = 0;
    resp_dly  = 0;
    req_addr  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_auto) begin
        mem_valid = stale_pulse;
        mem_data  = 32'hDEAD_BEEF;
        resp_busy = 1'b0;
      end else begin
        mem_valid = 1'b0;
        if (mem_rd_en) begin
          if (!resp_busy) begin
            resp_busy = 1'b1;
            resp_cnt  = 0;
            req_addr  = mem_addr;
            resp_dly  = rand_mode ? int'($urandom_range(1, 3)) : 0;
          end else if (mem_addr != req_addr) begin
            unstable++;
          end
          if (resp_cnt >= resp_dly) begin
            mem_valid = 1'b1;
            mem_data  = mem[mem_addr[7:0]];
            addr_log.push_back(mem_addr);
            resp_busy = 1'b0;
          end else begin
            resp_cnt++;
          end
        end else begin
          resp_busy = 1'b0;
        end
      end
    end
  end

  task automatic pulse_ready(input logic j, input logic [31:0] o);
    ready = 1'b1;
    jmp   = j;
    off   = o;
    @(negedge clk);
    ready = 1'b0;
    jmp   = 1'b0;
    off   = '0;
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!cmd_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_valid"}, cmd_valid, 1'b1);
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    int n = 0;
    while (mem_addr !== a && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_addr_reached"}, mem_addr, a);
  endtask

  initial begin
    int log_base;
    int unst_base;
    int viol;
    int n;

    rst         = 1'b1;
    start       = 1'b0;
    ready       = 1'b0;
    jmp         = 1'b0;
    off         = '0;
    mem_auto    = 1'b1;
    rand_mode   = 1'b0;
    stale_pulse = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0001;
    mem[0]   = 32'h0000_0088;
    mem[1]   = 32'h0000_0804;
    mem[2]   = 32'h0000_0005;
    mem[3]   = 32'h0000_0001;
    mem[255] = 32'h0000_003F;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_fl", cmd_fl, 6'h0);
    check("rst_cmd_arg", cmd_arg, 96'h0);
    check("rst_halted", halted, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rd_en", mem_rd_en, 1'b0);

    // argc 2 command at address 0
    log_base = addr_log.size();
    start = 1'b1;
    wait_cmd("cmd0");
    start = 1'b0;
    check("cmd0_fl", cmd_fl, 6'b001000);
    check("cmd0_arg", cmd_arg, 96'h0000_0000_0000_0005_0000_0804);
    check("cmd0_pc", pc, 32'h0);
    check("cmd0_nreads", addr_log.size() - log_base, 3);
    for (int i = 0; i < 3; i++) check("cmd0_read_addr", addr_log[log_base + i], i);

    // Sequential advance past header + 2 args
    pulse_ready(1'b0, 32'h0);
    check("seq_pc", pc, 32'h3);
    check("seq_mem_addr", mem_addr, 32'h3);
    check("seq_cmd_valid_drop", cmd_valid, 1'b0);
    wait_cmd("cmd3");
    check("cmd3_fl", cmd_fl, 6'h01);
    check("cmd3_arg_cleared", cmd_arg, 96'h0);
    check("cmd3_pc", pc, 32'h3);

    // Backward jump of -3 lands on the header at 0 again
    pulse_ready(1'b1, 32'hFFFF_FFFD);
    check("jmp_back_pc", pc, 32'h0);
    check("jmp_back_mem_addr", mem_addr, 32'h0);
    wait_cmd("refetch0");
    check("refetch0_fl", cmd_fl, 6'b001000);
    check("refetch0_arg", cmd_arg, 96'h0000_0000_0000_0005_0000_0804);

    // Jump of -1 from 0 wraps to the top of the address space
    pulse_ready(1'b1, 32'hFFFF_FFFF);
    check("wrap_pc", pc, 32'hFFFF_FFFF);
    check("wrap_mem_addr", mem_addr, 32'hFFFF_FFFF);
    wait_cmd("cmd_top");
    check("cmd_top_fl", cmd_fl, 6'h3F);
    check("cmd_top_arg", cmd_arg, 96'h0);

    // Jump +4 wraps to 3, which now holds a halt header
    mem[3] = 32'h0000_0000;
    pulse_ready(1'b1, 32'h0000_0004);
    check("halt_jmp_pc", pc, 32'h3);
    n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1'b1);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      ready = (i % 10 == 0);
      jmp   = ready;
      off   = 32'h5;
      @(negedge clk);
      if (mem_rd_en || cmd_valid || !halted) viol++;
    end
    ready = 1'b0;
    jmp   = 1'b0;
    off   = '0;
    check("halt_hold_violations", viol, 0);
    check("halt_pc_frozen", pc, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_halted", halted, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pc", pc, 32'h0);
    check("post_rst_rd_en", mem_rd_en, 1'b0);

    // argc 3 with random memory latency; READY pulses during argument fetch are ignored
    mem[0]    = 32'h0000_00D5;
    mem[1]    = 32'h1111_1111;
    mem[2]    = 32'h2222_2222;
    mem[3]    = 32'h3333_3333;
    rand_mode = 1'b1;
    unst_base = unstable;
    log_base  = addr_log.size();
    start     = 1'b1;
    wait_addr("arg3_fetch", 32'h1);
    start = 1'b0;
    ready = 1'b1;
    jmp   = 1'b1;
    off   = 32'h7;
    repeat (2) @(negedge clk);
    ready = 1'b0;
    jmp   = 1'b0;
    off   = '0;
    check("arg3_ready_ignored_pc", pc, 32'h0);
    check("arg3_still_fetching", mem_rd_en, 1'b1);
    wait_cmd("arg3");
    check("arg3_fl", cmd_fl, 6'h15);
    check("arg3_arg", cmd_arg, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    check("arg3_pc", pc, 32'h0);
    check("arg3_addr_stable", unstable - unst_base, 0);
    check("arg3_nreads", addr_log.size() - log_base, 4);
    for (int i = 0; i < 4; i++) check("arg3_read_addr", addr_log[log_base + i], i);
    pulse_ready(1'b0, 32'h0);
    check("arg3_seq_pc", pc, 32'h4);

    // Reset in the middle of argument fetch, followed by a stale read strobe
    mem[4] = 32'h0000_00C1;
    mem[5] = 32'hAAAA_AAAA;
    mem[6] = 32'hBBBB_BBBB;
    mem[7] = 32'hCCCC_CCCC;
    wait_addr("mid_fetch", 32'h6);
    mem_auto = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_en", mem_rd_en, 1'b0);
    check("mid_rst_arg", cmd_arg, 96'h0);
    rst         = 1'b0;
    stale_pulse = 1'b1;
    @(negedge clk);
    stale_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_rd_en", mem_rd_en, 1'b0);
    check("stale_cmd_valid", cmd_valid, 1'b0);
    check("stale_cmd_arg", cmd_arg, 96'h0);
    check("stale_cmd_fl", cmd_fl, 6'h0);
    check("stale_pc", pc, 32'h0);
    check("stale_mem_addr", mem_addr, 32'h0);
    check("stale_halted", halted, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
